// File: rtl/sdp_ram_pipe_if.sv
// Bus bundle for sdp_ram_pipe: clear control, write port and read port.
// The master drives requests; the slave (the RAM) drives read results and busy.
interface sdp_ram_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NB         = 2
);
  logic                  clr_req;
  logic                  init_busy;
  logic                  wr_en;
  logic [NB-1:0]         wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [NB-1:0]         rd_perr;

  modport master (
    output clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid, rd_perr
  );

  modport slave (
    input  clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid, rd_perr
  );
endinterface

// File: rtl/sdp_ram_pipe.sv
// Simple dual-port RAM with byte enables, RD_LATENCY-deep read pipeline,
// selectable read-during-write behaviour and a clear sequencer that zeroes
// the array after reset or on clr_req.
// Optional feature macro: SDP_RAM_PARITY_EN (one even-parity bit per byte,
// stored above the data bits and checked on read into rd_perr).
module sdp_ram_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 1024,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic           clk,
  input  logic           rst,
  sdp_ram_pipe_if.slave  bus
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
`ifdef SDP_RAM_PARITY_EN
  localparam int PW = NB;
`else
  localparam int PW = 0;
`endif
  // Stored word: data in the low bits, parity (if any) above it.
  localparam int MW = DATA_WIDTH + PW;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DATA_DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DATA_DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            busy;

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [NB-1:0]   mem_be;
  logic [MW-1:0]   mem_wdata;
  logic [MW-1:0]   mem_q [DATA_DEPTH];

  logic            wr_in_range, rd_in_range;
  logic            wr_fire, rd_fire;
  logic [MW-1:0]   rd_word;

  logic [MW-1:0]   dpipe_q    [1:RD_LATENCY];
  logic            vld_pipe_q [1:RD_LATENCY];

  // Out-of-range addresses only exist for non-power-of-2 depths.
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
  assign wr_fire     = !busy && bus.wr_en && wr_in_range;
  assign rd_fire     = !busy && bus.rd_en;

  // FSM state register: reset (even mid-clear) restarts clearing at address 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state: one word cleared per cycle, clr_req only honoured in READY
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // FSM outputs: busy flag and the write-port mux (clear sequencer vs user write)
  always_comb begin
    busy      = (state_q == CLEAR);
    mem_we    = 1'b0;
    mem_addr  = bus.wr_addr;
    mem_be    = bus.wr_be;
    mem_wdata = '0;
    if (busy) begin
      // zero data has zero even-parity, so an all-zero word is self-consistent
      mem_we   = 1'b1;
      mem_addr = ptr_q;
      mem_be   = '1;
    end else begin
      mem_we = wr_fire;
`ifdef SDP_RAM_PARITY_EN
      for (int b = 0; b < NB; b++)
        mem_wdata[DATA_WIDTH+b] = ^bus.wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
`endif
      mem_wdata[DATA_WIDTH-1:0] = bus.wr_data;
    end
  end

  // Array write, byte-granular; the array itself carries no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDP_RAM_PARITY_EN
          mem_q[mem_addr][DATA_WIDTH+b] <= mem_wdata[DATA_WIDTH+b];
`endif
        end
      end
    end
  end

  // Read word for this cycle: old contents, merged with the write when write-first
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem_q[bus.rd_addr];
    if (RDW_MODE == 1 && wr_fire && bus.wr_addr == bus.rd_addr) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) begin
          rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDP_RAM_PARITY_EN
          rd_word[DATA_WIDTH+b] = mem_wdata[DATA_WIDTH+b];
`endif
        end
      end
    end
  end

  // Read pipeline: data only advances with a live valid, busy flushes all stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= RD_LATENCY; k++) begin
        vld_pipe_q[k] <= 1'b0;
        dpipe_q[k]    <= '0;
      end
    end else begin
      vld_pipe_q[1] <= rd_fire;
      if (rd_fire) dpipe_q[1] <= rd_word;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1] && !busy;
        if (vld_pipe_q[k-1] && !busy) dpipe_q[k] <= dpipe_q[k-1];
      end
    end
  end

  assign bus.rd_data   = dpipe_q[RD_LATENCY][DATA_WIDTH-1:0];
  assign bus.rd_valid  = vld_pipe_q[RD_LATENCY];
  assign bus.init_busy = busy;

`ifdef SDP_RAM_PARITY_EN
  // Parity check on the output stage, reported only alongside rd_valid
  always_comb begin
    bus.rd_perr = '0;
    for (int b = 0; b < NB; b++)
      bus.rd_perr[b] = vld_pipe_q[RD_LATENCY] &&
        (dpipe_q[RD_LATENCY][DATA_WIDTH+b] != ^dpipe_q[RD_LATENCY][b*BYTE_WIDTH +: BYTE_WIDTH]);
  end
`else
  assign bus.rd_perr = '0;
`endif
endmodule
